// File: rtl/led_sequencer.sv
// Pattern scheduler for the LED bank: prescaled stepping through rotate, bounce,
// blink or count patterns, reconfigured through a valid/ready port.
module led_sequencer #(
   parameter int                LED_W       = 8,
   parameter int                DIV_W       = 24,
   parameter logic [DIV_W-1:0]  DEFAULT_DIV = DIV_W'(999),
   parameter logic [LED_W-1:0]  RESET_PAT   = LED_W'(8'h01)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [1:0]       cfg_mode,
   input  logic [DIV_W-1:0] cfg_div,
   input  logic [LED_W-1:0] cfg_pattern,
   input  logic             pause,
   output logic [LED_W-1:0] led,
   output logic             step,
   output logic             busy
);

   // state | meaning
   // RUN   | prescaler counting, led advances on terminal count
   // HOLD  | pause high, prescaler and led frozen
   // LOAD  | one cycle after a configuration is accepted
   typedef enum logic [1:0] {RUN, HOLD, LOAD} state_t;
   typedef enum logic [1:0] {ROTATE, BOUNCE, BLINK, COUNT} mode_t;

   state_t             state_q, state_nxt;
   mode_t              mode_q, mode_nxt;
   logic [DIV_W-1:0]   div_q, div_nxt;
   logic [DIV_W-1:0]   presc_q, presc_nxt;
   logic [LED_W-1:0]   pat_q, pat_nxt;
   logic [LED_W-1:0]   led_q, led_nxt;
   logic               dir_right_q, dir_right_nxt;
   logic               step_q, step_nxt;
   logic [LED_W-1:0]   adv_led;
   logic               adv_dir_right;
   logic               accept;
   logic               tick;

   assign cfg_ready = (state_q != LOAD);
   assign busy      = (state_q == LOAD);
   assign led       = led_q;
   assign step      = step_q;
   assign accept    = cfg_valid && cfg_ready;
   assign tick      = (presc_q == div_q);

   always_comb begin
      adv_led       = led_q;
      adv_dir_right = dir_right_q;
      case (mode_q)
         ROTATE: adv_led = {led_q[LED_W-2:0], led_q[LED_W-1]};
         BOUNCE: begin
            if (!dir_right_q && led_q[LED_W-1]) begin
               adv_dir_right = 1'b1;
               adv_led       = led_q >> 1;
            end else if (dir_right_q && led_q[0]) begin
               adv_dir_right = 1'b0;
               adv_led       = led_q << 1;
            end else if (dir_right_q) begin
               adv_led = led_q >> 1;
            end else begin
               adv_led = led_q << 1;
            end
         end
         BLINK:  adv_led = (led_q == pat_q) ? '0 : pat_q;
         COUNT:  adv_led = led_q + LED_W'(1);
         default: adv_led = led_q;
      endcase
   end

   always_comb begin
      state_nxt     = state_q;
      mode_nxt      = mode_q;
      div_nxt       = div_q;
      pat_nxt       = pat_q;
      led_nxt       = led_q;
      presc_nxt     = presc_q;
      dir_right_nxt = dir_right_q;
      step_nxt      = 1'b0;
      // a configuration wins over a tick landing in the same cycle
      if (accept) begin
         mode_nxt      = mode_t'(cfg_mode);
         div_nxt       = cfg_div;
         pat_nxt       = cfg_pattern;
         led_nxt       = cfg_pattern;
         presc_nxt     = '0;
         dir_right_nxt = 1'b0;
         state_nxt     = LOAD;
      end else begin
         case (state_q)
            LOAD: state_nxt = pause ? HOLD : RUN;
            HOLD: if (!pause) state_nxt = RUN;
            RUN: begin
               if (pause) begin
                  state_nxt = HOLD;
               end else if (tick) begin
                  presc_nxt     = '0;
                  led_nxt       = adv_led;
                  dir_right_nxt = adv_dir_right;
                  step_nxt      = 1'b1;
               end else begin
                  presc_nxt = presc_q + DIV_W'(1);
               end
            end
            default: state_nxt = RUN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= RUN;
         mode_q      <= ROTATE;
         div_q       <= DEFAULT_DIV;
         pat_q       <= RESET_PAT;
         led_q       <= RESET_PAT;
         presc_q     <= '0;
         dir_right_q <= 1'b0;
         step_q      <= 1'b0;
      end else begin
         state_q     <= state_nxt;
         mode_q      <= mode_nxt;
         div_q       <= div_nxt;
         pat_q       <= pat_nxt;
         led_q       <= led_nxt;
         presc_q     <= presc_nxt;
         dir_right_q <= dir_right_nxt;
         step_q      <= step_nxt;
      end
   end

endmodule

// File: tb/tb_led_sequencer.sv
// Randomized bench for led_sequencer: a behavioural model predicts each LED step
// into a queue that a separate monitor drains whenever the DUT pulses step.
module tb_led_sequencer;
   localparam int LED_W = 8;
   localparam int DIV_W = 24;
   localparam int DEF_DIV = 3;

   logic             clk = 1'b0;
   logic             rst;
   logic             cfg_valid;
   logic             cfg_ready;
   logic [1:0]       cfg_mode;
   logic [DIV_W-1:0] cfg_div;
   logic [LED_W-1:0] cfg_pattern;
   logic             pause;
   logic [LED_W-1:0] led;
   logic             step;
   logic             busy;

   led_sequencer #(
      .LED_W(LED_W), .DIV_W(DIV_W), .DEFAULT_DIV(24'd3), .RESET_PAT(8'h01)
   ) dut (
      .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_mode(cfg_mode), .cfg_div(cfg_div), .cfg_pattern(cfg_pattern),
      .pause(pause), .led(led), .step(step), .busy(busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit started = 0;

   // model: state 0=RUN 1=HOLD 2=LOAD; left = clocks of counting still owed before the next step
   int m_state, m_mode, m_div, m_pat, m_led, m_dir, m_left;
   int exp_q[$];

   task automatic advance();
      case (m_mode)
         0: m_led = ((m_led * 2) % 256) + (m_led / 128);
         1: begin
            if (m_dir == 0 && m_led >= 128) begin m_dir = 1; m_led = m_led / 2; end
            else if (m_dir == 1 && (m_led % 2) == 1) begin m_dir = 0; m_led = (m_led * 2) % 256; end
            else if (m_dir == 0) m_led = (m_led * 2) % 256;
            else m_led = m_led / 2;
         end
         2: m_led = (m_led == m_pat) ? 0 : m_pat;
         default: m_led = (m_led + 1) % 256;
      endcase
   endtask

   task automatic model_edge();
      if (rst) begin
         m_state = 0; m_mode = 0; m_div = DEF_DIV; m_pat = 1; m_led = 1; m_dir = 0; m_left = DEF_DIV;
      end else if (m_state != 2 && cfg_valid) begin
         m_mode = int'(cfg_mode); m_div = int'(cfg_div); m_pat = int'(cfg_pattern);
         m_led = m_pat; m_left = m_div; m_dir = 0; m_state = 2;
      end else if (m_state == 2) begin
         m_state = pause ? 1 : 0;
      end else if (m_state == 1) begin
         if (!pause) m_state = 0;
      end else if (pause) begin
         m_state = 1;
      end else if (m_left == 0) begin
         advance();
         m_left = m_div;
         exp_q.push_back(m_led);
      end else begin
         m_left = m_left - 1;
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      model_edge();
      started = 1;
      @(negedge clk);
      #1;
   endtask

   task automatic cfg(input int mode, input int div, input int pat);
      cfg_valid = 1'b1;
      cfg_mode = 2'(mode);
      cfg_div = DIV_W'(div);
      cfg_pattern = LED_W'(pat);
      cyc();
      cfg_valid = 1'b0;
   endtask

   task automatic wait_for(input int st, input int left, input string name);
      int n = 0;
      while (!(m_state == st && m_left == left) && n < 30) begin
         cyc();
         n++;
      end
      checks++;
      if (n >= 30) begin
         errors++;
         $display("FAIL %s: wait budget expired, state %0d left %0d", name, m_state, m_left);
      end
   endtask

   always @(negedge clk) begin
      if (started) begin
         checks++;
         if (cfg_ready !== (m_state != 2)) begin
            errors++;
            $display("FAIL cfg_ready: got %b expected %b", cfg_ready, (m_state != 2));
         end
         checks++;
         if (busy !== (m_state == 2)) begin
            errors++;
            $display("FAIL busy: got %b expected %b", busy, (m_state == 2));
         end
         checks++;
         if (led !== LED_W'(m_led)) begin
            errors++;
            $display("FAIL led: got %02h expected %02h", led, m_led[7:0]);
         end
         if (step === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL step_unexpected: got step=1 led=%02h expected no step", led);
            end else begin
               int e;
               e = exp_q.pop_front();
               if (led !== LED_W'(e)) begin
                  errors++;
                  $display("FAIL step_led: got %02h expected %02h", led, e[7:0]);
               end
            end
         end else if (exp_q.size() != 0) begin
            int e;
            checks++;
            errors++;
            e = exp_q.pop_front();
            $display("FAIL step_missing: got step=%b expected step=1 led=%02h", step, e[7:0]);
         end
      end
   end

   initial begin
      rst = 1'b1; cfg_valid = 1'b0; pause = 1'b0;
      cfg_mode = '0; cfg_div = '0; cfg_pattern = '0;
      @(negedge clk);
      cyc(); cyc();
      rst = 1'b0;
      repeat (40) cyc();

      cfg(0, 0, 'h81);  repeat (6) cyc();
      cfg(1, 1, 'h40);  repeat (40) cyc();
      cfg(2, 2, 'hA5);  repeat (15) cyc();
      cfg(3, 2, 'hFE);  repeat (15) cyc();

      cfg(0, 3, 'h01);
      wait_for(0, 2, "pause_setup");
      pause = 1'b1; repeat (10) cyc();
      pause = 1'b0; repeat (8) cyc();

      wait_for(0, 0, "tick_setup");
      cfg(2, 1, 'h3C);  repeat (6) cyc();
      cfg(3, 2, 'h10);
      rst = 1'b1; cyc();
      rst = 1'b0; repeat (10) cyc();

      repeat (3000) begin
         cfg_valid   = ($urandom % 12) == 0;
         cfg_mode    = 2'($urandom % 4);
         cfg_div     = DIV_W'($urandom_range(0, 5));
         cfg_pattern = 8'($urandom);
         pause       = ($urandom % 6) == 0;
         rst         = ($urandom % 250) == 0;
         cyc();
      end
      rst = 1'b0; cfg_valid = 1'b0; pause = 1'b0;
      repeat (3) cyc();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
